regfile_scan_ctrl: RTL and testbench

Post-run register-file scan controller that sits between the processor and the regfile. On request it halts the processor and waits a fixed drain interval. It then takes over read port A, gates off regfile writes, and streams all register values out over a valid/ready interface. It is the hardware counterpart of the bench's register-check phase, used for on-board debug of Simon-game firmware.

---
 rtl/regfile_scan_ctrl_if.sv | 39 +++
 rtl/regfile_scan_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_regfile_scan_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scan_ctrl_if.sv
// -----------------------------------------------------------------------------
// regfile_scan_ctrl_if
//
// Purpose: valid/ready stream that carries register-file words out of the
// scan controller. One word is transferred on every rising clock edge where
// scan_valid and scan_ready are both high.
//
// Signals:
//   scan_valid  producer -> consumer  word available
//   scan_ready  consumer -> producer  consumer accepts word
//   scan_data   producer -> consumer  32-bit register value
//   scan_index  producer -> consumer  register number of scan_data
//   scan_last   producer -> consumer  high with the final word of a scan
//
// Modports: master = scan controller (producer), slave = consumer.
// -----------------------------------------------------------------------------
interface regfile_scan_ctrl_if;
  logic        scan_valid;
  logic        scan_ready;
  logic [31:0] scan_data;
  logic [4:0]  scan_index;
  logic        scan_last;

  modport master (
    output scan_valid,
    output scan_data,
    output scan_index,
    output scan_last,
    input  scan_ready
  );

  modport slave (
    input  scan_valid,
    input  scan_data,
    input  scan_index,
    input  scan_last,
    output scan_ready
  );
endinterface

// File: rtl/regfile_scan_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_scan_ctrl
//
// Purpose: post-run register-file scan controller for on-board debug. On a
// start request it halts the processor, waits DRAIN_CYCLES for in-flight work
// to settle, then takes over regfile read port A, blocks regfile writes and
// streams registers 0..NUM_REGS-1 out over a valid/ready stream.
//
// Parameters:
//   NUM_REGS      number of registers scanned (2..32)
//   DRAIN_CYCLES  cycles the processor is held before the scan (1..15)
//
// Compile-time option:
//   SCAN_CHECKSUM_EN  when defined, checksum accumulates the sum (mod 2^32) of
//                     every word handed over on the stream; when undefined,
//                     checksum is tied to zero and no adder exists.
//
// Ports:
//   clock, reset      single clock, synchronous active-high reset
//   start             scan request, only looked at while idle
//   cpu_rs1, cpu_rwe  processor read-A address / write enable
//   rs1_out, rwe_out  to regfile: pass-through while idle, scan-owned otherwise
//   reg_a             regfile read-A data (combinational read of rs1_out)
//   cpu_halt          registered processor clock-enable kill
//   scan              valid/ready word stream (master side)
//   busy              high whenever the controller is not idle
//   done              one-cycle pulse after the final word is accepted
//   checksum          sum of emitted words (see SCAN_CHECKSUM_EN)
// -----------------------------------------------------------------------------
module regfile_scan_ctrl #(
  parameter int NUM_REGS     = 32,
  parameter int DRAIN_CYCLES = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       start,
  input  logic [4:0]                 cpu_rs1,
  input  logic                       cpu_rwe,
  output logic [4:0]                 rs1_out,
  output logic                       rwe_out,
  input  logic [31:0]                reg_a,
  output logic                       cpu_halt,
  regfile_scan_ctrl_if.master        scan,
  output logic                       busy,
  output logic                       done,
  output logic [31:0]                checksum
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRAIN = 3'd1,
    S_FETCH = 3'd2,
    S_SEND  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [4:0] LAST_IDX   = 5'(NUM_REGS - 1);
  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic [4:0]  idx_q, idx_d;
  logic [31:0] data_q, data_d;
  logic [4:0]  sidx_q, sidx_d;
  logic        last_q, last_d;
  logic        halt_q, halt_d;
  logic        handshake;

  assign handshake = (state_q == S_SEND) && scan.scan_ready;

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d         = state_q;
    drain_cnt_d     = drain_cnt_q;
    idx_d           = idx_q;
    data_d          = data_q;
    sidx_d          = sidx_q;
    last_d          = last_q;
    // Outside IDLE the controller owns read port A and writes are blocked.
    rs1_out         = idx_q;
    rwe_out         = 1'b0;
    busy            = 1'b1;
    done            = 1'b0;
    scan.scan_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        rs1_out = cpu_rs1;
        rwe_out = cpu_rwe;
        busy    = 1'b0;
        if (start) begin
          state_d     = S_DRAIN;
          drain_cnt_d = DRAIN_LOAD;
          idx_d       = 5'd0;
        end
      end

      S_DRAIN: begin
        if (drain_cnt_q == 4'd0) begin
          state_d = S_FETCH;
        end else begin
          drain_cnt_d = drain_cnt_q - 4'd1;
        end
      end

      // rs1_out already presents idx_q, so reg_a holds that register's value.
      S_FETCH: begin
        data_d  = reg_a;
        sidx_d  = idx_q;
        last_d  = (idx_q == LAST_IDX);
        state_d = S_SEND;
      end

      // Word registers are untouched here, so they stay stable while stalled.
      S_SEND: begin
        scan.scan_valid = 1'b1;
        if (handshake) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            idx_d   = idx_q + 5'd1;
            state_d = S_FETCH;
          end
        end
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Halt follows the next state so it rises right after start is accepted
    // and falls on the edge that leaves DONE.
    halt_d = (state_d != S_IDLE);
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      drain_cnt_q <= 4'd0;
      idx_q       <= 5'd0;
      data_q      <= 32'd0;
      sidx_q      <= 5'd0;
      last_q      <= 1'b0;
      halt_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      idx_q       <= idx_d;
      data_q      <= data_d;
      sidx_q      <= sidx_d;
      last_q      <= last_d;
      halt_q      <= halt_d;
    end
  end

  assign cpu_halt        = halt_q;
  assign scan.scan_data  = data_q;
  assign scan.scan_index = sidx_q;
  assign scan.scan_last  = last_q;

  // ---------------------------------------------------------------------------
  // Optional running checksum of accepted words
  // ---------------------------------------------------------------------------
`ifdef SCAN_CHECKSUM_EN
  logic [31:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if ((state_q == S_IDLE) && start) begin
      sum_d = 32'd0;
    end else if (handshake) begin
      sum_d = sum_q + data_q;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sum_q <= 32'd0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`else
  assign checksum = 32'd0;
`endif

endmodule

// File: tb/tb_regfile_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_scan_ctrl
//
// Bench for regfile_scan_ctrl with NUM_REGS=32, DRAIN_CYCLES=4. A small
// regfile holds r_i = i*3. A reference model derives, from the start edge and
// the handshake edges, when each word must be offered and what every output
// must be; a compare process checks the DUT against it on every cycle.
// Directed scenarios add hand-computed literal expectations.
// -----------------------------------------------------------------------------
module tb_regfile_scan_ctrl;
  localparam int NUM_REGS     = 32;
  localparam int DRAIN_CYCLES = 4;
`ifdef SCAN_CHECKSUM_EN
  localparam logic [31:0] EXP_SUM = 32'd1488;
`else
  localparam logic [31:0] EXP_SUM = 32'd0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  cpu_rs1 = 5'd0;
  logic        cpu_rwe = 1'b0;
  logic [4:0]  rs1_out;
  logic        rwe_out;
  logic [31:0] reg_a;
  logic        cpu_halt;
  logic        busy;
  logic        done;
  logic [31:0] checksum;

  // bench regfile
  logic [4:0]  wr_addr = 5'd0;
  logic [31:0] wr_data = 32'd0;
  logic        rf_load = 1'b1;
  logic [31:0] rf [32];

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  regfile_scan_ctrl_if scan_if();

  regfile_scan_ctrl #(
    .NUM_REGS     (NUM_REGS),
    .DRAIN_CYCLES (DRAIN_CYCLES)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .start    (start),
    .cpu_rs1  (cpu_rs1),
    .cpu_rwe  (cpu_rwe),
    .rs1_out  (rs1_out),
    .rwe_out  (rwe_out),
    .reg_a    (reg_a),
    .cpu_halt (cpu_halt),
    .scan     (scan_if.master),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] exp_word(input int i);
    return 32'(i * 3);
  endfunction

  always @(posedge clock) begin
    if (rf_load) begin
      for (int i = 0; i < 32; i++) rf[i] <= exp_word(i);
    end else if (rwe_out && wr_addr != 5'd0) begin
      rf[wr_addr] <= wr_data;
    end
  end

  assign reg_a = (rs1_out == 5'd0) ? 32'd0 : rf[rs1_out];

  // ---------------------------------------------------------------------------
  // Reference model: the scan is described by the start edge, the edge after
  // which the current word must be offered, and the final handshake edge.
  // ---------------------------------------------------------------------------
  int          edge_n   = 0;
  bit          m_active = 1'b0;
  int          m_word   = 0;
  int          m_vfrom  = 0;
  int          m_end    = -1;
  logic [31:0] m_sum    = 32'd0;
  int          hs_total   = 0;
  int          done_total = 0;

  always @(posedge clock) begin
    edge_n <= edge_n + 1;
    if (!reset && scan_if.scan_valid && scan_if.scan_ready) begin
      hs_total <= hs_total + 1;
      $display("word idx=%0d data=%0d last=%0b edge=%0d",
               scan_if.scan_index, scan_if.scan_data, scan_if.scan_last, edge_n);
    end
    if (!reset && done) begin
      done_total <= done_total + 1;
      $display("scan complete edge=%0d checksum=%0d", edge_n, checksum);
    end

    if (reset) begin
      m_active <= 1'b0;
      m_word   <= 0;
      m_end    <= -1;
      m_sum    <= 32'd0;
    end else if (!m_active) begin
      if (start) begin
        m_active <= 1'b1;
        m_word   <= 0;
        m_vfrom  <= edge_n + DRAIN_CYCLES + 1;
        m_end    <= -1;
        m_sum    <= 32'd0;
      end
    end else if (m_end >= 0) begin
      m_active <= 1'b0;
    end else if (edge_n > m_vfrom && scan_if.scan_ready) begin
      m_sum <= m_sum + exp_word(m_word);
      if (m_word == NUM_REGS - 1) begin
        m_end <= edge_n;
      end else begin
        m_word  <= m_word + 1;
        m_vfrom <= edge_n + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at edge %0d",
               name, act, act, exp, exp, edge_n);
    end
  endtask

  task automatic compare_loop();
    bit ev;
    forever begin
      @(negedge clock);
      if (chk_en) begin
        ev = m_active && (m_end < 0) && ((edge_n - 1) >= m_vfrom);
        chk("busy", 32'(busy), 32'(m_active));
        chk("cpu_halt", 32'(cpu_halt), 32'(m_active));
        chk("done", 32'(done), 32'(m_active && (m_end >= 0)));
        chk("scan_valid", 32'(scan_if.scan_valid), 32'(ev));
        chk("rwe_out", 32'(rwe_out), m_active ? 32'd0 : 32'(cpu_rwe));
        chk("rs1_out", 32'(rs1_out), m_active ? 32'(m_word) : 32'(cpu_rs1));
`ifdef SCAN_CHECKSUM_EN
        chk("checksum", checksum, m_sum);
`else
        chk("checksum", checksum, 32'd0);
`endif
        if (ev) begin
          chk("scan_data", scan_if.scan_data, exp_word(m_word));
          chk("scan_index", 32'(scan_if.scan_index), 32'(m_word));
          chk("scan_last", 32'(scan_if.scan_last), 32'(m_word == NUM_REGS - 1));
        end
      end
    end
  endtask

  // start is high for exactly one sampled edge; e0 is that edge's number
  task automatic pulse_start(output int e0);
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 e0 = edge_n - 1;
    start = 1'b0;
  endtask

  task automatic wait_valid_idx(input int idx, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (scan_if.scan_valid && (scan_if.scan_index == 5'(idx))) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (scan_if.scan_valid) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_done(output int de, output bit ok);
    ok = 1'b0;
    de = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (done) begin
        de = edge_n - 1;
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, de, hs0, d0;
    bit ok;

    scan_if.scan_ready = 1'b0;
    fork
      compare_loop();
    join_none

    // reset and pass-through
    reset = 1'b1; rf_load = 1'b1;
    cpu_rs1 = 5'd7; cpu_rwe = 1'b1; wr_addr = 5'd7; wr_data = 32'd21;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0; rf_load = 1'b0;
    @(negedge clock);
    chk("rst_rs1_out", 32'(rs1_out), 32'd7);
    chk("rst_rwe_out", 32'(rwe_out), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_halt", 32'(cpu_halt), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(scan_if.scan_valid), 32'd0);
    chk("rst_data", scan_if.scan_data, 32'd0);
    chk("rst_index", 32'(scan_if.scan_index), 32'd0);
    chk("rst_last", 32'(scan_if.scan_last), 32'd0);
    chk("rst_checksum", checksum, 32'd0);
    chk_en = 1'b1;
    #1 cpu_rwe = 1'b0; cpu_rs1 = 5'd0;

    // basic scan
    scan_if.scan_ready = 1'b1;
    hs0 = hs_total; d0 = done_total;
    pulse_start(e0);
    @(negedge clock);
    chk("halt_after_start", 32'(cpu_halt), 32'd1);
    wait_done(de, ok);
    chk("basic_done_seen", 32'(ok), 32'd1);
    chk("basic_done_latency", 32'(de - e0), 32'd68);
    chk("basic_checksum", checksum, EXP_SUM);
    @(negedge clock);
    chk("basic_idle_busy", 32'(busy), 32'd0);
    chk("basic_words", 32'(hs_total - hs0), 32'd32);
    chk("basic_done_pulses", 32'(done_total - d0), 32'd1);
    chk("basic_checksum_hold", checksum, EXP_SUM);

    // backpressure on word 5
    hs0 = hs_total;
    pulse_start(e0);
    wait_valid_idx(4, ok);
    chk("bp_reach4", 32'(ok), 32'd1);
    @(posedge clock);
    #1 scan_if.scan_ready = 1'b0;
    wait_valid_idx(5, ok);
    chk("bp_reach5", 32'(ok), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(scan_if.scan_valid), 32'd1);
      chk("bp_data", scan_if.scan_data, 32'd15);
      chk("bp_index", 32'(scan_if.scan_index), 32'd5);
      @(negedge clock);
    end
    #1 scan_if.scan_ready = 1'b1;
    wait_done(de, ok);
    chk("bp_done_seen", 32'(ok), 32'd1);
    @(negedge clock);
    chk("bp_words", 32'(hs_total - hs0), 32'd32);
    chk("bp_checksum", checksum, EXP_SUM);

    // write gating
    cpu_rs1 = 5'd3; wr_addr = 5'd3; wr_data = 32'hDEAD_BEEF;
    pulse_start(e0);
    cpu_rwe = 1'b1;
    wait_done(de, ok);
    chk("wg_done_seen", 32'(ok), 32'd1);
    #1 cpu_rwe = 1'b0;
    @(negedge clock);
    for (int i = 0; i < 32; i++) chk("wg_rf_intact", rf[i], exp_word(i));
    cpu_rs1 = 5'd0; wr_addr = 5'd0; wr_data = 32'd0;

    // reset mid-scan at index 12
    pulse_start(e0);
    wait_valid_idx(12, ok);
    chk("mr_reach12", 32'(ok), 32'd1);
    reset = 1'b1;
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_halt", 32'(cpu_halt), 32'd0);
    chk("mr_valid", 32'(scan_if.scan_valid), 32'd0);
    chk("mr_checksum", checksum, 32'd0);
    hs0 = hs_total;
    pulse_start(e0);
    wait_valid(ok);
    chk("mr_first_valid", 32'(ok), 32'd1);
    chk("mr_first_index", 32'(scan_if.scan_index), 32'd0);
    chk("mr_first_data", scan_if.scan_data, 32'd0);
    wait_done(de, ok);
    chk("mr_done_latency", 32'(de - e0), 32'd68);
    @(negedge clock);
    chk("mr_words", 32'(hs_total - hs0), 32'd32);

    // start ignored while busy (once in DRAIN, once in SEND)
    hs0 = hs_total; d0 = done_total;
    pulse_start(e0);
    @(posedge clock);
    #1 start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_valid_idx(3, ok);
    chk("si_reach3", 32'(ok), 32'd1);
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    wait_done(de, ok);
    chk("si_done_latency", 32'(de - e0), 32'd68);
    repeat (4) @(negedge clock);
    chk("si_words", 32'(hs_total - hs0), 32'd32);
    chk("si_done_pulses", 32'(done_total - d0), 32'd1);
    chk("si_idle", 32'(busy), 32'd0);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
